// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for the async FIFO: pops show-ahead words into a
// 2-entry registered valid/ready buffer, with flush and beat/drop counters.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  beat_cnt,
    output logic [CNT_WIDTH-1:0]  drop_cnt
);

    logic [1:0]            count;
    logic [1:0]            count_nxt;
    logic [DATA_WIDTH-1:0] tail;
    logic [DATA_WIDTH-1:0] head_nxt;
    logic [DATA_WIDTH-1:0] tail_nxt;
    logic                  xfer;
    logic                  take;
    logic [1:0]            drop_inc;

    // rst gates the pop so the FIFO never loses a word while we are held in reset
    assign fifo_rd_en = !rst && !fifo_empty && (flush || count != 2'd2);
    assign xfer       = m_valid && m_ready;
    assign take       = fifo_rd_en && !flush;
    assign drop_inc   = count - {1'b0, xfer} + {1'b0, fifo_rd_en};

    always_comb begin
        count_nxt = count;
        head_nxt  = m_data;
        tail_nxt  = tail;
        if (flush) begin
            count_nxt = 2'd0;
        end else begin
            unique case (count)
                2'd0: begin
                    if (take) begin
                        head_nxt  = fifo_dout;
                        count_nxt = 2'd1;
                    end
                end
                2'd1: begin
                    if (take && !xfer) begin
                        tail_nxt  = fifo_dout;
                        count_nxt = 2'd2;
                    end else if (take) begin
                        head_nxt  = fifo_dout;
                    end else if (xfer) begin
                        count_nxt = 2'd0;
                    end
                end
                2'd2: begin
                    if (xfer) begin
                        head_nxt  = tail;
                        count_nxt = 2'd1;
                    end
                end
                default: count_nxt = 2'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= 2'd0;
            m_data   <= '0;
            tail     <= '0;
            m_valid  <= 1'b0;
            beat_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            count    <= count_nxt;
            m_data   <= head_nxt;
            tail     <= tail_nxt;
            m_valid  <= (count_nxt != 2'd0);
            beat_cnt <= beat_cnt + CNT_WIDTH'(xfer);
            if (flush)
                drop_cnt <= drop_cnt + CNT_WIDTH'(drop_inc);
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed + random bench for fifo_rd_stream: FIFO model, word scoreboard,
// and a second narrow-counter instance for wrap-around.
module tb_fifo_rd_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic       w_rd_en;
    logic [7:0] m_data;
    logic [7:0] w_m_data;
    logic       m_valid;
    logic       w_m_valid;
    logic       m_ready;
    logic       flush;
    logic [15:0] beat_cnt;
    logic [15:0] drop_cnt;
    logic [3:0]  w_beat_cnt;
    logic [3:0]  w_drop_cnt;

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush), .beat_cnt(beat_cnt), .drop_cnt(drop_cnt)
    );

    fifo_rd_stream #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_w (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(w_rd_en),
        .m_data(w_m_data), .m_valid(w_m_valid), .m_ready(m_ready),
        .flush(flush), .beat_cnt(w_beat_cnt), .drop_cnt(w_drop_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int         mcnt;
    int         beats;
    int         drops;
    int         pops;
    logic       gate;
    logic [7:0] wtag;
    logic [7:0] base;
    int         n_total;
    int         n_pass;
    int         n_fail;
    int         b0;
    int         p0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int n);
        repeat (n) begin
            fifo_q.push_back(wtag);
            exp_q.push_back(wtag);
            wtag++;
        end
    endtask

    task automatic tick();
        logic exp_rd;
        logic xf;
        int   d;
        fifo_empty = gate || (fifo_q.size() == 0);
        fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'hEE;
        #1;
        exp_rd = !rst && !fifo_empty && (flush || mcnt < 2);
        xf     = (mcnt != 0) && m_ready;
        chk("rd_en", fifo_rd_en, exp_rd);
        chk("m_valid", m_valid, mcnt != 0);
        chk("w_m_valid", w_m_valid, mcnt != 0);
        if (mcnt != 0 && exp_q.size() != 0)
            chk("m_data", m_data, exp_q[0]);
        @(posedge clk);
        #1;
        if (xf) begin
            void'(exp_q.pop_front());
            beats++;
        end
        if (exp_rd)
            void'(fifo_q.pop_front());
        if (flush) begin
            d = mcnt - int'(xf) + int'(exp_rd);
            drops += d;
            repeat (d) void'(exp_q.pop_front());
            mcnt = 0;
        end else begin
            if (exp_rd) pops++;
            mcnt = mcnt - int'(xf) + int'(exp_rd);
        end
        chk("beat_cnt", beat_cnt, beats[15:0]);
        chk("drop_cnt", drop_cnt, drops[15:0]);
        chk("w_beat_cnt", w_beat_cnt, beats[3:0]);
        chk("w_drop_cnt", w_drop_cnt, drops[3:0]);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; m_ready = 1'b0; gate = 1'b0;
        fifo_empty = 1'b1; fifo_dout = 8'h00; wtag = 8'h00;
        mcnt = 0; beats = 0; drops = 0; pops = 0;
        n_total = 0; n_pass = 0; n_fail = 0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_beat", beat_cnt, 16'd0);
        chk("rst_drop", drop_cnt, 16'd0);
        rst = 1'b0;

        // streaming 0x00..0x0F
        m_ready = 1'b1;
        push(16);
        tick();
        chk("first_valid", m_valid, 1'b1);
        chk("first_data", m_data, 8'h00);
        repeat (19) tick();
        chk("stream_beats", beat_cnt, 16'd16);
        chk("stream_drops", drop_cnt, 16'd0);

        // narrow counter wraps after 18 beats
        push(2);
        repeat (4) tick();
        chk("wrap_w_beat", w_beat_cnt, 4'd2);
        chk("wrap_beat", beat_cnt, 16'd18);

        // backpressure
        m_ready = 1'b0;
        push(5);
        repeat (4) tick();
        chk("bp_stall_rd_en", fifo_rd_en, 1'b0);
        chk("bp_head", m_data, 8'h12);
        m_ready = 1'b1;
        repeat (8) tick();
        chk("bp_beats", beat_cnt, 16'd23);

        // flush with full buffer and 3 words left in the FIFO
        m_ready = 1'b0;
        push(5);
        repeat (3) tick();
        chk("pre_flush_valid", m_valid, 1'b1);
        m_ready = 1'b1;
        flush = 1'b1;
        repeat (5) tick();
        flush = 1'b0;
        chk("flush_drop", drop_cnt, 16'd4);
        chk("flush_beat", beat_cnt, 16'd24);
        chk("flush_valid", m_valid, 1'b0);
        chk("flush_fifo_left", fifo_q.size(), 0);
        tick();

        // reset mid-stream at count 2
        m_ready = 1'b0;
        base = wtag;
        push(4);
        repeat (3) tick();
        chk("pre_rst_valid", m_valid, 1'b1);
        rst = 1'b1;
        fifo_empty = (fifo_q.size() == 0);
        #1;
        chk("mid_rst_valid", m_valid, 1'b0);
        chk("mid_rst_rd_en", fifo_rd_en, 1'b0);
        chk("mid_rst_beat", beat_cnt, 16'd0);
        chk("mid_rst_drop", drop_cnt, 16'd0);
        repeat (mcnt) void'(exp_q.pop_front());
        mcnt = 0; beats = 0; drops = 0;
        @(negedge clk);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        chk("post_rst_word", m_data, base + 8'd2);
        repeat (4) tick();

        // random traffic
        b0 = beats;
        p0 = pops;
        repeat (10000) begin
            gate = ($urandom_range(0, 3) == 0);
            m_ready = $urandom_range(0, 1) != 0;
            if (fifo_q.size() < 6 && $urandom_range(0, 1) != 0)
                push($urandom_range(1, 3));
            tick();
        end
        gate = 1'b0;
        m_ready = 1'b1;
        repeat (12) tick();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_beats_eq_pops", beat_cnt - b0[15:0], 16'(pops - p0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain stage placed directly downstream of the asynchronous FIFO, in the FIFO's read-clock domain. It pops words from the FIFO's show-ahead read port (`dout`, `empty`, `rd_en`) and presents them as a registered valid/ready stream through a 2-entry buffer, at full throughput. It also provides a flush mechanism that drains and discards the FIFO and the buffer, and keeps wrap-around counters of delivered and discarded beats.

## Interface
- `DATA_WIDTH`, 8: word width; must equal the FIFO data width.
- `CNT_WIDTH`, 16: width of the `beat_cnt` and `drop_cnt` statistics counters.
- `clk` input 1: read-domain clock; the same clock that drives the FIFO read port.
- `rst` input 1: asynchronous, active-high reset.
- `fifo_dout` input DATA_WIDTH: FIFO head word. It is valid in the same cycle that `fifo_empty`=0 (show-ahead).
- `fifo_empty` input 1: FIFO empty flag.
- `fifo_rd_en` output 1: combinational pop request to the FIFO.
- `m_data` output DATA_WIDTH: output word (registered head of the buffer).
- `m_valid` output 1: output word valid (registered).
- `m_ready` input 1: downstream accepts the word.
- `flush` input 1: level-sensitive discard request.
- `beat_cnt` output CNT_WIDTH: number of beats accepted downstream, modulo 2^CNT_WIDTH.
- `drop_cnt` output CNT_WIDTH: number of beats discarded by flush, modulo 2^CNT_WIDTH.

## Operation
- **Storage**
  - Two entries: head (drives `m_data`) and tail.
  - `count` ranges 0..2.
  - `m_valid` = (count != 0), held in a register.
- **Pop rule**
  - `fifo_rd_en` = !rst & !fifo_empty & (flush | count < 2).
  - A word is captured whenever `fifo_rd_en`=1 and `flush`=0.
- **Transfer:** occurs when `m_valid` & `m_ready` at a rising edge.
- **Normal-mode updates** (`flush`=0), per clock edge:
  - count 0, pop: head <= fifo_dout; count becomes 1.
  - count 1, pop, no transfer: tail <= fifo_dout; count becomes 2.
  - count 1, pop, transfer: head <= fifo_dout; count stays 1.
  - count 1, transfer only: count becomes 0.
  - count 2, transfer: head <= tail; count becomes 1. No pop is possible at count 2.
  - Otherwise the state holds.
  - `m_data` and `m_valid` are stable while `m_valid`=1 and `m_ready`=0.
- **Flush mode** (`flush`=1):
  - Every FIFO pop is discarded and increments `drop_cnt` by 1.
  - In any cycle with `flush`=1, a concurrent transfer (`m_valid` & `m_ready`) counts toward `beat_cnt`.
  - Buffer entries not transferred in that cycle are discarded and added to `drop_cnt`: count minus the transfer (0..2).
  - count becomes 0, so `m_valid`=0 from the next cycle on.
  - `drop_cnt` increment per cycle = discarded buffer entries + (pop ? 1 : 0). The maximum is 3 in the first flush cycle; after that it is 0 or 1 per cycle.
  - Flush stays active as long as it is held. Normal operation resumes the cycle after deassertion, starting at count 0.
- **Counters:** `beat_cnt` increments on each transfer. Both counters wrap silently from all-ones to 0.

## Timing
- **Reset values:**
  - `m_valid`=0, `m_data`=0, count=0, tail=0, `beat_cnt`=0, `drop_cnt`=0.
  - `fifo_rd_en`=0 while `rst`=1.
- **Latency:** when `fifo_empty` falls in cycle N (with count<2 and no flush), `fifo_rd_en`=1 in cycle N and `m_valid`=1 with that word from cycle N+1.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, one beat per cycle is sustained at count=1.
- **Backpressure:** a stall reaching count 2 deasserts `fifo_rd_en` in the same cycle that count==2 is observed.
- **`fifo_rd_en` depends combinationally on `fifo_empty`**, which the FIFO may assert asynchronously. Pops are qualified only at the rising edge, and no other path from `fifo_dout` or `fifo_empty` to an output is allowed.
- **Reset mid-operation:** all state clears immediately and buffered words are lost without being counted. `fifo_rd_en` drops in the same instant.
- **Ordering:** words leave in exactly the order they were popped. There is no duplication or loss outside of flush.

## Test plan
- **Reset:** assert `rst` mid-stream with count=2 -> `m_valid`=0, `fifo_rd_en`=0, both counters read 0, and the first word after release is the next FIFO word.
- **Streaming:** 16 words 0x00..0x0F, `m_ready`=1 -> first `m_valid` one cycle after the first pop; 16 consecutive beats in order; `beat_cnt`=16, `drop_cnt`=0.
- **Backpressure:** 5 words queued, `m_ready`=0 for 4 cycles, then 1 -> count saturates at 2 and `fifo_rd_en`=0 during the stall; output order is 0,1,2,3,4 with no gaps once `m_ready`=1.
- **Flush with full buffer:** count=2, 3 words remain in the FIFO, `flush` held high for 5 cycles with `m_ready`=1 -> the head is transferred (`beat_cnt`+1); `drop_cnt`=4 (1 buffer entry + 3 FIFO words); `m_valid`=0 and `fifo_empty`=1 at the end.
- **Counter wrap:** CNT_WIDTH=4, 18 beats -> `beat_cnt` reads 2.
- **Random traffic:** random `fifo_empty` and `m_ready` over 10k cycles -> a scoreboard confirms order is preserved, `m_data` is stable during stalls, and `beat_cnt` equals the number of pops.
